shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
//   Parametrised multi-cycle shifter for the ALU/EX stage. Successor to the fixed
//   32-bit shift-by-1 logic: variable shift amount, selectable SLL/SRL/SRA modes,
//   and a configurable number of bit positions per clock.
//   Sits beside the single-cycle ALU ops; valid/ready on both sides so the EX stall
//   logic can hold the pipeline while a shift is in flight.
// PARAMETERS
//   WIDTH  32  data width; power of two, >= 8
//   STEP   1   max bit positions shifted per cycle; 1..WIDTH
//   SHW    $clog2(WIDTH)  shift-amount width (derived, localparam)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request this cycle
//   op         in   2      00 SLL, 01 SRL, 10 SRA, 11 see CONFIGURATION
//   B          in   WIDTH  operand to shift
//   shamt      in   SHW    shift amount
//   out_valid  out  1      res holds a finished result
//   out_ready  in   1      consumer takes result this cycle
//   res        out  WIDTH  shifted result
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, res=0, out_valid=0, in_ready=1 after release; internal regs 0.
// - FSM IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: on in_valid&&in_ready latch B into res, op and rem=shamt.
//     Next state is SHIFT if shamt!=0, else DONE.
//   - SHIFT: each cycle shift res by k=min(rem,STEP); rem-=k; go to DONE when rem<=STEP.
//   - DONE: out_valid=1; res stable until out_valid&&out_ready.
//     On that handshake: IDLE, or directly load a new request if in_valid.
// - in_ready = (state==IDLE) || (state==DONE && out_ready): back-to-back ops with no bubble.
//   A request accepted in the same cycle as the result handshake loads new operands.
//   The retiring result is the one sampled by the consumer in that cycle.
// - Latency: out_valid rises L = 1 + ceil(shamt/STEP) cycles after the accepting cycle.
//   shamt=0 gives L=1, with res=B.
// - Shifts per step:
//   - SLL: zero-fill at LSB.
//   - SRL: zero-fill at MSB.
//   - SRA: replicate res[WIDTH-1], the sign latched at accept.
// - Result bit-exact to B<<shamt, B>>shamt, $signed(B)>>>shamt for any STEP.
// - Inputs are ignored unless accepted; op/B/shamt may change freely while busy.
// - out_valid never drops without out_ready; res never changes while out_valid=1.
// - rst asserted mid-SHIFT or in DONE aborts the op; the result is discarded, no out_valid.
// CONFIGURATION
//   SHIFT_UNIT_ROTATE_EN
//   - defined: op 11 = ROR; each step rotates res right by k; bits wrap MSB-ward.
//     Latency follows the same L rule.
//   - undefined: op 11 is reserved. It is accepted and completes with L=1 and res=B,
//     regardless of shamt. No rotate logic is synthesised.
// TESTING
//   1 WIDTH=32 STEP=1: SRL B=32'h8000_0001 shamt=1 -> res=32'h4000_0000, out_valid 2 cycles after accept.
//   2 STEP=4: SRA B=32'hF000_0000 shamt=13 -> res=32'hFFFF_8000, L=5.
//     SLL B=1 shamt=31 -> res=32'h8000_0000, L=9.
//   3 shamt=0, any op -> res=B, L=1.
//     Two requests back-to-back with out_ready=1 -> second accepted in first's DONE cycle, no idle cycle.
//   4 out_ready=0 for 5 cycles in DONE -> res/out_valid held, in_ready=0; then release -> single handshake.
//   5 rst pulse during SHIFT (shamt=20, STEP=1, cycle 6) -> out_valid=0, res=0, IDLE.
//     A following request completes correctly.
//   6 op=11 B=32'h0000_00F1 shamt=4: with ROTATE_EN -> 32'h1000_000F;
//     without -> 32'h0000_00F1, L=1.

Source files
------------

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle SLL/SRL/SRA shifter with valid/ready on both sides.
// Shifts up to STEP bit positions per clock until the requested amount is consumed.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN (op 11 = rotate right when defined,
// otherwise op 11 is a reserved pass-through that completes immediately).
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Step size widened by one bit so STEP == WIDTH is representable.
  localparam logic [SHW:0] STEP_V = (SHW+1)'(STEP);
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [SHW:0] WIDTH_V = (SHW+1)'(WIDTH);
`endif

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   rem_q, rem_d;

  logic [SHW:0]     rem_ext;
  logic [SHW:0]     k;
  logic [WIDTH-1:0] shifted;
  logic             load;
  logic             skip;

  // Amount shifted this cycle: whatever remains, capped at STEP.
  always_comb begin
    rem_ext = {1'b0, rem_q};
    k       = (rem_ext < STEP_V) ? rem_ext : STEP_V;
  end

  // One step of the selected shift applied to the working register.
  always_comb begin
    shifted = res_q;
    case (op_q)
      OP_SLL:  shifted = res_q << k;
      OP_SRL:  shifted = res_q >> k;
      OP_SRA:  shifted = $signed(res_q) >>> k;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR:  shifted = (res_q >> k) | (res_q << (WIDTH_V - k));
`endif
      default: shifted = res_q;
    endcase
  end

  // Handshake outputs: a new request may enter while the current result retires.
  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    res       = res_q;
    load      = in_valid && in_ready;
`ifdef SHIFT_UNIT_ROTATE_EN
    skip      = (shamt == '0);
`else
    skip      = (shamt == '0) || (op == 2'b11);
`endif
  end

  // Next-state and datapath updates; a load overrides the retire-to-IDLE path.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        res_d = shifted;
        rem_d = rem_q - k[SHW-1:0];
        if (rem_ext <= STEP_V) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      op_d    = op_e'(op);
      res_d   = B;
      rem_d   = skip ? '0 : shamt;
      state_d = skip ? DONE : SHIFT;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: directed bench for shift_unit_iter, one STEP=1 and one STEP=4 instance.
module tb_shift_unit_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
  logic [1:0]  op1 = 2'b00;
  logic [31:0] bb1 = '0, rs1;
  logic [4:0]  sh1 = '0;

  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
  logic [1:0]  op4 = 2'b00;
  logic [31:0] bb4 = '0, rs4;
  logic [4:0]  sh4 = '0;

  int n_cmp = 0;
  int n_err = 0;

  shift_unit_iter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op1), .B(bb1),
    .shamt(sh1), .out_valid(ov1), .out_ready(or1), .res(rs1)
  );

  shift_unit_iter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4), .B(bb4),
    .shamt(sh4), .out_valid(ov4), .out_ready(or4), .res(rs4)
  );

  always #5 clk = ~clk;

  // Issue one request to the chosen instance, measure latency, capture result, retire it.
  task automatic do_op(input int which, input logic [1:0] o, input logic [31:0] b,
                       input logic [4:0] s, output logic [31:0] r, output int lat);
    @(negedge clk);
    if (which == 1) begin iv1 = 1'b1; op1 = o; bb1 = b; sh1 = s; end
    else            begin iv4 = 1'b1; op4 = o; bb4 = b; sh4 = s; end
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    op1 = ~o; bb1 = ~b; sh1 = ~s;
    op4 = ~o; bb4 = ~b; sh4 = ~s;
    lat = 1;
    while ((((which == 1) ? ov1 : ov4) !== 1'b1) && (lat < 200)) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) lat = -1;
    r = (which == 1) ? rs1 : rs4;
    @(negedge clk);
    or1 = 1'b1; or4 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0; or4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ov1: got %b expected 0", ov1); end
    n_cmp++; if (rs1 !== 32'h0) begin n_err++; $display("[TB] FAIL reset_res1: got %h expected 00000000", rs1); end
    n_cmp++; if (ov4 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ov4: got %b expected 0", ov4); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ir1: got %b expected 1", ir1); end
    n_cmp++; if (ir4 !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ir4: got %b expected 1", ir4); end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    int lat;
    do_op(1, 2'b01, 32'h8000_0001, 5'd1, r, lat);
    n_cmp++; if (r !== 32'h4000_0000) begin n_err++; $display("[TB] FAIL srl1_res: got %h expected 40000000", r); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL srl1_lat: got %0d expected 2", lat); end
    do_op(4, 2'b10, 32'hF000_0000, 5'd13, r, lat);
    n_cmp++; if (r !== 32'hFFFF_8000) begin n_err++; $display("[TB] FAIL sra4_res: got %h expected ffff8000", r); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL sra4_lat: got %0d expected 5", lat); end
    do_op(4, 2'b00, 32'h0000_0001, 5'd31, r, lat);
    n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("[TB] FAIL sll4_res: got %h expected 80000000", r); end
    n_cmp++; if (lat !== 9) begin n_err++; $display("[TB] FAIL sll4_lat: got %0d expected 9", lat); end
    do_op(4, 2'b00, 32'h0000_00FF, 5'd8, r, lat);
    n_cmp++; if (r !== 32'h0000_FF00) begin n_err++; $display("[TB] FAIL sll4x8_res: got %h expected 0000ff00", r); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("[TB] FAIL sll4x8_lat: got %0d expected 3", lat); end
    do_op(4, 2'b01, 32'h8000_0000, 5'd31, r, lat);
    n_cmp++; if (r !== 32'h0000_0001) begin n_err++; $display("[TB] FAIL srl4_res: got %h expected 00000001", r); end
    n_cmp++; if (lat !== 9) begin n_err++; $display("[TB] FAIL srl4_lat: got %0d expected 9", lat); end
    do_op(4, 2'b10, 32'h7FFF_FFFF, 5'd4, r, lat);
    n_cmp++; if (r !== 32'h07FF_FFFF) begin n_err++; $display("[TB] FAIL sra4pos_res: got %h expected 07ffffff", r); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL sra4pos_lat: got %0d expected 2", lat); end
    do_op(1, 2'b10, 32'h8000_0000, 5'd31, r, lat);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL sra1_res: got %h expected ffffffff", r); end
    n_cmp++; if (lat !== 32) begin n_err++; $display("[TB] FAIL sra1_lat: got %0d expected 32", lat); end
    do_op(1, 2'b00, 32'h1234_5678, 5'd4, r, lat);
    n_cmp++; if (r !== 32'h2345_6780) begin n_err++; $display("[TB] FAIL sll1_res: got %h expected 23456780", r); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL sll1_lat: got %0d expected 5", lat); end
  endtask

  task automatic test_zero_shift();
    logic [31:0] r;
    int lat;
    for (int o = 0; o < 4; o++) begin
      do_op(1, 2'(o), 32'hA5A5_1234, 5'd0, r, lat);
      n_cmp++; if (r !== 32'hA5A5_1234) begin n_err++; $display("[TB] FAIL zero1_res op%0d: got %h expected a5a51234", o, r); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("[TB] FAIL zero1_lat op%0d: got %0d expected 1", o, lat); end
      do_op(4, 2'(o), 32'h5A5A_CDEF, 5'd0, r, lat);
      n_cmp++; if (r !== 32'h5A5A_CDEF) begin n_err++; $display("[TB] FAIL zero4_res op%0d: got %h expected 5a5acdef", o, r); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("[TB] FAIL zero4_lat op%0d: got %0d expected 1", o, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    iv1 = 1'b1; op1 = 2'b00; bb1 = 32'h0000_0ABC; sh1 = 5'd0; or1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_first_valid: got %b expected 1", ov1); end
    n_cmp++; if (rs1 !== 32'h0000_0ABC) begin n_err++; $display("[TB] FAIL b2b_first_res: got %h expected 00000abc", rs1); end
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready_in_done: got %b expected 1", ir1); end
    op1 = 2'b00; bb1 = 32'h0000_0003; sh1 = 5'd2;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_second_busy: got %b expected 0", ov1); end
    lat = 1;
    while ((ov1 !== 1'b1) && (lat < 200)) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 3) begin n_err++; $display("[TB] FAIL b2b_second_lat: got %0d expected 3", lat); end
    n_cmp++; if (rs1 !== 32'h0000_000C) begin n_err++; $display("[TB] FAIL b2b_second_res: got %h expected 0000000c", rs1); end
    @(posedge clk); #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_retired: got %b expected 0", ov1); end
    or1 = 1'b0;
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    @(negedge clk);
    iv1 = 1'b1; op1 = 2'b01; bb1 = 32'hDEAD_BEEF; sh1 = 5'd3; or1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0; bb1 = 32'h0; sh1 = 5'd7;
    lat = 1;
    while ((ov1 !== 1'b1) && (lat < 200)) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 4) begin n_err++; $display("[TB] FAIL hold_lat: got %0d expected 4", lat); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      iv1 = 1'b1;
      @(posedge clk); #1;
      if (ov1 !== 1'b1 || rs1 !== 32'h1BD5_B7DD || ir1 !== 1'b0) bad++;
    end
    iv1 = 1'b0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0", bad); end
    n_cmp++; if (rs1 !== 32'h1BD5_B7DD) begin n_err++; $display("[TB] FAIL hold_res: got %h expected 1bd5b7dd", rs1); end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL hold_release: got %b expected 0", ov1); end
    @(posedge clk); #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL hold_single: got %b expected 0", ov1); end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int lat;
    int bad;
    @(negedge clk);
    iv1 = 1'b1; op1 = 2'b00; bb1 = 32'h0000_0003; sh1 = 5'd20;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b expected 0", ov1); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rs1 !== 32'h0) begin n_err++; $display("[TB] FAIL abort_res: got %h expected 00000000", rs1); end
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("[TB] FAIL abort_ov: got %b expected 0", ov1); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("[TB] FAIL abort_idle: got %b expected 1", ir1); end
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ov1 !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("[TB] FAIL abort_no_valid: got %0d cycles expected 0", bad); end
    do_op(1, 2'b00, 32'h0000_0003, 5'd20, r, lat);
    n_cmp++; if (r !== 32'h0030_0000) begin n_err++; $display("[TB] FAIL abort_next_res: got %h expected 00300000", r); end
    n_cmp++; if (lat !== 21) begin n_err++; $display("[TB] FAIL abort_next_lat: got %0d expected 21", lat); end
  endtask

  task automatic test_rotate();
    logic [31:0] r;
    int lat;
`ifdef SHIFT_UNIT_ROTATE_EN
    do_op(1, 2'b11, 32'h0000_00F1, 5'd4, r, lat);
    n_cmp++; if (r !== 32'h1000_000F) begin n_err++; $display("[TB] FAIL ror1_res: got %h expected 1000000f", r); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL ror1_lat: got %0d expected 5", lat); end
    do_op(4, 2'b11, 32'h0000_00F1, 5'd4, r, lat);
    n_cmp++; if (r !== 32'h1000_000F) begin n_err++; $display("[TB] FAIL ror4_res: got %h expected 1000000f", r); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL ror4_lat: got %0d expected 2", lat); end
`else
    do_op(1, 2'b11, 32'h0000_00F1, 5'd4, r, lat);
    n_cmp++; if (r !== 32'h0000_00F1) begin n_err++; $display("[TB] FAIL rsv1_res: got %h expected 000000f1", r); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("[TB] FAIL rsv1_lat: got %0d expected 1", lat); end
    do_op(4, 2'b11, 32'h0000_00F1, 5'd31, r, lat);
    n_cmp++; if (r !== 32'h0000_00F1) begin n_err++; $display("[TB] FAIL rsv4_res: got %h expected 000000f1", r); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("[TB] FAIL rsv4_lat: got %0d expected 1", lat); end
`endif
  endtask

  // Run every scenario in order and report the totals.
  initial begin
    $display("[TB] shift_unit_iter directed bench start");
    test_reset();
    test_basic();
    test_zero_shift();
    test_back_to_back();
    test_hold();
    test_abort();
    test_rotate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
